// File: rtl/jtag_tap_regs.sv
// JTAG IR/BYPASS/IDCODE register stage driven by the decoded TAP state; TDO is combinational.
// Optional USER DR is built only when JTAG_USER_DR_EN is defined; otherwise USER selects BYPASS.
module jtag_tap_regs #(
  parameter int              IR_W         = 4,
  parameter int              DR_W         = 8,
  parameter logic [31:0]     IDCODE       = 32'h1234_5679,
  parameter logic [IR_W-1:0] INSTR_IDCODE = IR_W'(4'h1),
  parameter logic [IR_W-1:0] INSTR_USER   = IR_W'(4'h2)
) (
  input  logic            CLK,
  input  logic            RESETN,
  input  logic [3:0]      state,
  input  logic            tdi,
  output logic            tdo,
  output logic            tdo_en,
  output logic [IR_W-1:0] ir,
  input  logic [DR_W-1:0] user_capture,
  output logic [DR_W-1:0] user_update,
  output logic            user_update_stb
);

  localparam logic [3:0] TLR    = 4'd15;
  localparam logic [3:0] CAP_DR = 4'd6;
  localparam logic [3:0] SH_DR  = 4'd2;
  localparam logic [3:0] UPD_DR = 4'd5;
  localparam logic [3:0] CAP_IR = 4'd14;
  localparam logic [3:0] SH_IR  = 4'd10;
  localparam logic [3:0] UPD_IR = 4'd13;

  logic [IR_W-1:0] ir_sr;
  logic [31:0]     id_sr;
  logic            byp;
  logic            sel_id;
  logic            sel_usr;
  logic            usr_lsb;

  // All-ones is always BYPASS, even if a parameter collides with it.
  assign sel_id = (ir == INSTR_IDCODE) && (ir != {IR_W{1'b1}});

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      ir    <= INSTR_IDCODE;
      ir_sr <= '0;
      id_sr <= '0;
      byp   <= 1'b0;
    end else begin
      case (state)
        TLR:    ir <= INSTR_IDCODE;
        CAP_IR: ir_sr <= IR_W'(1);
        SH_IR:  ir_sr <= {tdi, ir_sr[IR_W-1:1]};
        UPD_IR: ir <= ir_sr;
        CAP_DR: begin
          if (sel_id) id_sr <= IDCODE;
          else if (!sel_usr) byp <= 1'b0;
        end
        SH_DR: begin
          if (sel_id) id_sr <= {tdi, id_sr[31:1]};
          else if (!sel_usr) byp <= tdi;
        end
        default: ;
      endcase
    end
  end

`ifdef JTAG_USER_DR_EN
  logic [DR_W-1:0] usr_sr;

  assign sel_usr = (ir == INSTR_USER) && !sel_id && (ir != {IR_W{1'b1}});
  assign usr_lsb = usr_sr[0];

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      usr_sr          <= '0;
      user_update     <= '0;
      user_update_stb <= 1'b0;
    end else begin
      user_update_stb <= 1'b0;
      if (sel_usr) begin
        case (state)
          CAP_DR: usr_sr <= user_capture;
          // Shift form that also holds for a 1-bit register.
          SH_DR:  usr_sr <= (usr_sr >> 1) | (DR_W'(tdi) << (DR_W - 1));
          UPD_DR: begin
            user_update     <= usr_sr;
            user_update_stb <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
`else
  logic unused_cap;

  assign sel_usr         = 1'b0;
  assign usr_lsb         = 1'b0;
  assign user_update     = '0;
  assign user_update_stb = 1'b0;
  assign unused_cap      = ^{user_capture, INSTR_USER};
`endif

  assign tdo_en = (state == SH_IR) || (state == SH_DR);

  always_comb begin
    tdo = 1'b0;
    if (state == SH_IR) tdo = ir_sr[0];
    else if (state == SH_DR) tdo = sel_id ? id_sr[0] : (sel_usr ? usr_lsb : byp);
  end

endmodule

// File: tb/tb_jtag_tap_regs.sv
// Directed bench for jtag_tap_regs: TAP states are driven directly, TDO sampled mid-cycle.
module tb_jtag_tap_regs;

  localparam logic [3:0] TLR = 4'd15, RTI = 4'd12, SEL_DR = 4'd7, CAP_DR = 4'd6,
                         SH_DR = 4'd2, EX1_DR = 4'd1, PA_DR = 4'd3, EX2_DR = 4'd0,
                         UPD_DR = 4'd5, SEL_IR = 4'd4, CAP_IR = 4'd14, SH_IR = 4'd10,
                         EX1_IR = 4'd9, UPD_IR = 4'd13;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic [3:0] state = TLR;
  logic       tdi = 1'b0;
  logic       tdo, tdo_en;
  logic [3:0] ir;
  logic [7:0] user_capture = 8'h00;
  logic [7:0] user_update;
  logic       user_update_stb;

  int n_cmp = 0;
  int n_bad = 0;

  jtag_tap_regs dut (
    .CLK(CLK), .RESETN(RESETN), .state(state), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .ir(ir), .user_capture(user_capture), .user_update(user_update),
    .user_update_stb(user_update_stb)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set(input logic [3:0] s, input logic d);
    state = s;
    tdi   = d;
    #1;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input logic [3:0] s);
    set(s, 1'b0);
    tick();
  endtask

  // Shift n bits in state s, collecting tdo LSB-first and counting tdo_en.
  task automatic shift(input logic [3:0] s, input int n, input logic [31:0] din,
                       output logic [31:0] dout, output int en_cnt);
    dout   = '0;
    en_cnt = 0;
    for (int i = 0; i < n; i++) begin
      set(s, din[i]);
      dout[i] = tdo;
      if (tdo_en) en_cnt++;
      tick();
    end
  endtask

  task automatic ir_scan(input logic [3:0] code);
    logic [31:0] d;
    int          e;
    step(SEL_DR);
    step(SEL_IR);
    step(CAP_IR);
    shift(SH_IR, 4, {28'h0, code}, d, e);
    step(EX1_IR);
    step(UPD_IR);
  endtask

  logic [31:0] dout;
  int          en;

  initial begin
    // Reset state
    set(TLR, 1'b0);
    tick();
    RESETN = 1'b1;
    check("rst_ir", ir, 4'h1);
    check("rst_tdo", tdo, 0);
    check("rst_tdo_en", tdo_en, 0);
    check("rst_uupd", user_update, 0);
    check("rst_stb", user_update_stb, 0);

    // 1: IDCODE stream
    step(TLR); step(RTI); step(SEL_DR); step(CAP_DR);
    shift(SH_DR, 32, 32'h0, dout, en);
    check("t1_idcode", dout, 32'h1234_5679);
    check("t1_en_cnt", en, 32);
    set(EX1_DR, 1'b0);
    check("t1_en_off", tdo_en, 0);
    tick();
    step(UPD_DR);

    // 2: IR scan of 4'h2
    step(SEL_DR); step(SEL_IR); step(CAP_IR);
    shift(SH_IR, 4, 32'b0010, dout, en);
    check("t2_ir_tdo", dout, 32'b0001);
    check("t2_ir_en", en, 4);
    step(EX1_IR);
    check("t2_ir_hold", ir, 4'h1);
    step(UPD_IR);
    check("t2_ir_upd", ir, 4'h2);

    // 3: BYPASS one-bit delay
    ir_scan(4'hF);
    check("t3_ir", ir, 4'hF);
    step(SEL_DR); step(CAP_DR);
    shift(SH_DR, 3, 32'b101, dout, en);
    check("t3_byp", dout, 32'b010);
    step(EX1_DR);
    step(UPD_DR);
    check("t3_stb", user_update_stb, 0);
    step(TLR);
    check("t3_tlr_ir", ir, 4'h1);

    // 4: USER DR (or BYPASS when the USER DR is not built)
    step(RTI);
    ir_scan(4'h2);
    check("t4_ir", ir, 4'h2);
    user_capture = 8'hA5;
    step(SEL_DR); step(CAP_DR);
    shift(SH_DR, 8, 32'h3C, dout, en);
    step(EX1_DR);
    step(UPD_DR);
`ifdef JTAG_USER_DR_EN
    check("t4_usr_tdo", dout, 32'hA5);
    check("t4_uupd", user_update, 8'h3C);
    check("t4_stb_hi", user_update_stb, 1);
    step(RTI);
    check("t4_stb_lo", user_update_stb, 0);
    check("t4_uupd_hold", user_update, 8'h3C);
`else
    check("t4_byp_tdo", dout, 32'h78);
    check("t4_uupd", user_update, 0);
    check("t4_stb", user_update_stb, 0);
    step(RTI);
    check("t4_stb_lo", user_update_stb, 0);
`endif

    // 5: reset in the middle of a DR shift
    step(SEL_DR); step(CAP_DR);
    shift(SH_DR, 5, 32'h1F, dout, en);
    set(SH_DR, 1'b1);
    RESETN = 1'b0;
    tick();
    RESETN = 1'b1;
    set(SH_DR, 1'b0);
    check("t5_ir", ir, 4'h1);
    check("t5_tdo", tdo, 0);
    step(EX1_DR); step(UPD_DR); step(SEL_DR); step(CAP_DR);
    shift(SH_DR, 32, 32'h0, dout, en);
    check("t5_idcode", dout, 32'h1234_5679);
    check("t5_uupd", user_update, 0);
    step(EX1_DR); step(UPD_DR);

    // 6: pause mid-shift and resume
    step(SEL_DR); step(CAP_DR);
    shift(SH_DR, 4, 32'h0, dout, en);
    check("t6_lo_nib", dout, 32'h9);
    step(EX1_DR);
    for (int i = 0; i < 10; i++) step(PA_DR);
    set(PA_DR, 1'b0);
    check("t6_pa_tdo", tdo, 0);
    check("t6_pa_en", tdo_en, 0);
    step(EX2_DR);
    shift(SH_DR, 4, 32'h0, dout, en);
    check("t6_resume", dout, 32'h7);
    check("t6_ir_hold", ir, 4'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
